siren_gen: RTL
==============

// Module: siren_gen
// PURPOSE
//  Parametrised multi-mode siren/tone generator driving a differential piezo pair (spkp/spkm).
//  Adds runtime mode select over the fixed wail generator: fast wail, slow wail, alternating wail,
//  two-tone hi-lo, steady tone and off. Adds an enable and glitch-free mode switching.
//  Sits directly behind the PLL clock in the music tops; mode/en come from buttons or a sequencer.
// PARAMETERS
//  CNT_W     28      width of free-running sweep timebase tone_cnt
//  DIV_W     15      width of half-period divider/counter
//  SWEEP_W   7       width of triangle sweep value
//  SHIFT     6       sweep LSB position in divider: div = (1<<(DIV_W-2)) + (sweep<<SHIFT)
//  FAST_BIT  22      tone_cnt bit selecting fast-triangle direction; sweep = tone_cnt[FAST_BIT-1 -: SWEEP_W]
//  SLOW_BIT  25      same for slow triangle
//  HILO_BIT  24      tone_cnt bit selecting HI_DIV/LO_DIV in hi-lo mode
//  HI_DIV    9000    hi-lo high-pitch divider (DIV_W bits)
//  LO_DIV    12000   hi-lo low-pitch and steady-mode divider
// PORTS
//  clk      in   1      system clock (25 MHz from PLL)
//  resetn   in   1      asynchronous active-low reset
//  en       in   1      1 = sound requested
//  mode     in   3      0 OFF, 1 FAST, 2 SLOW, 3 ALT, 4 HILO, 5 STEADY, 6/7 reserved (=OFF)
//  spkp     out  1      speaker +, registered
//  spkm     out  1      speaker -, registered
//  busy     out  1      1 while state RUN
//  period   out  DIV_W  divider in use for current half-period (0 in IDLE)
// BEHAVIOUR
//  Reset (resetn=0, async): state IDLE, tone_cnt=0, counter=0, spk=0, spkp=0, spkm=0, busy=0, period=0.
//  tone_cnt: increments every clk from reset release, wraps at 2^CNT_W; independent of en/mode/state.
//  Triangle: tri(B) = tone_cnt[B] ? tone_cnt[B-1 -: SWEEP_W] : ~tone_cnt[B-1 -: SWEEP_W].
//  Divider next_div by mode: FAST tri(FAST_BIT); SLOW tri(SLOW_BIT); ALT tone_cnt[CNT_W-1]?SLOW:FAST;
//   HILO tone_cnt[HILO_BIT]?HI_DIV:LO_DIV; STEADY LO_DIV. Sweep divider math DIV_W-bit, no overflow
//   at defaults (range 8192..16320).
//  valid = en && mode in 1..5.
//  FSM IDLE: spkp=spkm=0, counter held 0. valid at edge N -> RUN at N: counter=next_div,
//   period=next_div, spk=0 (spkp=0, spkm=1), busy=1.
//  FSM RUN: counter!=0 -> counter-1, outputs hold. counter==0 (half-period end):
//   valid -> spk toggles, counter=period=next_div (new mode/divider takes effect only here);
//   !valid -> IDLE, spkp=spkm=0, busy=0, period=0 (no toggle).
//  Half-period = period+1 clk; no truncated half-periods on mode change or en drop.
//  en/mode changes mid half-period are ignored until counter==0; a pulse of en or mode that
//   returns before counter==0 has no effect.
//  spkm = ~spkp in RUN; both 0 in IDLE (no DC across transducer).
//  Reset mid-operation: outputs 0 immediately, without waiting for clk.
// TESTING
//  Test params CNT_W=12, FAST_BIT=8, SLOW_BIT=10, HILO_BIT=9, SHIFT=0, DIV_W=9, HI_DIV=20, LO_DIV=40.
//   With DIV_W=9, sweep base is 128; tri values are 0..127; sweep divider range 128..255.
//  T1 reset: resetn=0, random en/mode -> spkp=spkm=busy=0, period=0; release, en=0 -> stays IDLE.
//  T2 mode=5, en=1 -> busy next edge, period=40, spkp toggles every 41 clk, spkm==~spkp throughout.
//  T3 mode=4 held -> period alternates 40/20 as tone_cnt[9] flips; changes only at toggle edges.
//  T4 mode=1 -> period tracks 128+tri(8): at tone_cnt=0 divider 255; reaches 128 then rises.
//  T5 en drops 5 clk into a 41-clk half-period -> spkp/spkm hold until counter==0, then both 0,
//   busy=0; en pulse of 3 clk while IDLE-bound mid-period -> no effect.
//  T6 mode 5->4 mid half-period -> current half-period completes at 41 clk, next uses HILO divider;
//   resetn=0 mid-RUN -> outputs 0 same cycle (async).

Source files
------------

// File: rtl/siren_gen.sv
// Multi-mode siren/tone generator for a differential piezo pair.
// A new divider and mode are only picked up at half-period boundaries, so mode changes never produce short pulses.
module siren_gen #(
  parameter int unsigned CNT_W    = 28,
  parameter int unsigned DIV_W    = 15,
  parameter int unsigned SWEEP_W  = 7,
  parameter int unsigned SHIFT    = 6,
  parameter int unsigned FAST_BIT = 22,
  parameter int unsigned SLOW_BIT = 25,
  parameter int unsigned HILO_BIT = 24,
  parameter logic [DIV_W-1:0] HI_DIV = DIV_W'(9000),
  parameter logic [DIV_W-1:0] LO_DIV = DIV_W'(12000)
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             en,
  input  logic [2:0]       mode,
  output logic             spkp,
  output logic             spkm,
  output logic             busy,
  output logic [DIV_W-1:0] period
);

  typedef enum logic {IDLE, RUN} state_t;

  typedef enum logic [2:0] {
    M_OFF    = 3'd0,
    M_FAST   = 3'd1,
    M_SLOW   = 3'd2,
    M_ALT    = 3'd3,
    M_HILO   = 3'd4,
    M_STEADY = 3'd5
  } mode_t;

  localparam logic [DIV_W-1:0] SWEEP_BASE = DIV_W'(1) << (DIV_W - 2);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   tone_cnt_q;
  logic [DIV_W-1:0]   counter_q, counter_d;
  logic [DIV_W-1:0]   period_q, period_d;
  logic               spkp_q, spkp_d;
  logic               spkm_q, spkm_d;

  logic [SWEEP_W-1:0] fast_sweep, slow_sweep;
  logic [DIV_W-1:0]   fast_div, slow_div, next_div;
  logic               valid;

  // Triangle sweep: the direction bit folds the ramp so it descends then ascends.
  assign fast_sweep = tone_cnt_q[FAST_BIT] ? tone_cnt_q[FAST_BIT-1 -: SWEEP_W]
                                           : ~tone_cnt_q[FAST_BIT-1 -: SWEEP_W];
  assign slow_sweep = tone_cnt_q[SLOW_BIT] ? tone_cnt_q[SLOW_BIT-1 -: SWEEP_W]
                                           : ~tone_cnt_q[SLOW_BIT-1 -: SWEEP_W];
  assign fast_div   = SWEEP_BASE + (DIV_W'(fast_sweep) << SHIFT);
  assign slow_div   = SWEEP_BASE + (DIV_W'(slow_sweep) << SHIFT);

  // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and infers a latch.
  always_comb begin
    next_div = '0;
    valid    = en;
    case (mode)
      M_FAST:   next_div = fast_div;
      M_SLOW:   next_div = slow_div;
      M_ALT:    next_div = tone_cnt_q[CNT_W-1] ? slow_div : fast_div;
      M_HILO:   next_div = tone_cnt_q[HILO_BIT] ? HI_DIV : LO_DIV;
      M_STEADY: next_div = LO_DIV;
      default:  valid    = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    period_d  = period_q;
    spkp_d    = spkp_q;
    spkm_d    = spkm_q;
    case (state_q)
      IDLE: begin
        counter_d = '0;
        period_d  = '0;
        spkp_d    = 1'b0;
        spkm_d    = 1'b0;
        if (valid) begin
          state_d   = RUN;
          counter_d = next_div;
          period_d  = next_div;
          spkm_d    = 1'b1;
        end
      end
      RUN: begin
        if (counter_q != '0) begin
          counter_d = counter_q - 1'b1;
        end else if (valid) begin
          counter_d = next_div;
          period_d  = next_div;
          spkp_d    = ~spkp_q;
          spkm_d    = spkp_q;
        end else begin
          state_d  = IDLE;
          period_d = '0;
          spkp_d   = 1'b0;
          spkm_d   = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q    <= IDLE;
      tone_cnt_q <= '0;
      counter_q  <= '0;
      period_q   <= '0;
      spkp_q     <= 1'b0;
      spkm_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tone_cnt_q <= tone_cnt_q + 1'b1;
      counter_q  <= counter_d;
      period_q   <= period_d;
      spkp_q     <= spkp_d;
      spkm_q     <= spkm_d;
    end
  end

  assign spkp   = spkp_q;
  assign spkm   = spkm_q;
  assign busy   = (state_q == RUN);
  assign period = period_q;

endmodule
